tnew_scoreboard: RTL and testbench

TNEW_SCOREBOARD -- requirements
Module: tnew_scoreboard

---
 rtl/tnew_scoreboard_if.sv | 25 ++
 rtl/tnew_scoreboard.sv | 34 +++
 tb/tb_tnew_scoreboard.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/tnew_scoreboard_if.sv
// tnew_scoreboard_if: issue-side request and hazard-status bundle for the Tnew/Tuse scoreboard
interface tnew_scoreboard_if #(parameter int NREG = 32, parameter int TNEW_W = 2);
  localparam int RW = $clog2(NREG);
  logic              issue_valid;
  logic [RW-1:0]     issue_rd;
  logic [TNEW_W-1:0] issue_tnew;
  logic              issue_md;
  logic [RW-1:0]     rs;
  logic [RW-1:0]     rt;
  logic [TNEW_W-1:0] tuse_rs;
  logic [TNEW_W-1:0] tuse_rt;
  logic              use_md;
  logic              stall;
  logic              md_busy;
  logic [TNEW_W-1:0] pend_rs;
  logic [TNEW_W-1:0] pend_rt;
  modport master (
    output issue_valid, issue_rd, issue_tnew, issue_md, rs, rt, tuse_rs, tuse_rt, use_md,
    input  stall, md_busy, pend_rs, pend_rt
  );
  modport slave (
    input  issue_valid, issue_rd, issue_tnew, issue_md, rs, rt, tuse_rs, tuse_rt, use_md,
    output stall, md_busy, pend_rs, pend_rt
  );
endinterface

// File: rtl/tnew_scoreboard.sv
// tnew_scoreboard: per-GPR Tnew countdown and mult/div busy tracking with zero-latency issue stall
module tnew_scoreboard #(
  parameter int NREG      = 32,
  parameter int TNEW_W    = 2,
  parameter int MD_CYCLES = 5
) (
  input logic clk,
  input logic reset,
  tnew_scoreboard_if.slave bus
);
  localparam int RW = $clog2(NREG);
  logic [TNEW_W-1:0] cnt [NREG];
  logic [4:0]        md;
  logic              accept;
  assign bus.pend_rs = cnt[bus.rs];
  assign bus.pend_rt = cnt[bus.rt];
  assign bus.md_busy = md != 5'd0;
  // equal Tnew/Tuse is safe: the result reaches the forwarding path just in time
  assign bus.stall = !reset && bus.issue_valid &&
                     (cnt[bus.rs] > bus.tuse_rs || cnt[bus.rt] > bus.tuse_rt ||
                      (bus.md_busy && (bus.use_md || bus.issue_md)));
  assign accept = !reset && bus.issue_valid && !bus.stall;
  // entry 0 is only ever written by reset, so it stays zero
  always_ff @(posedge clk or posedge reset)
    if (reset)
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    else
      for (int r = 1; r < NREG; r++)
        cnt[r] <= (accept && bus.issue_rd == RW'(r)) ? bus.issue_tnew :
                  (cnt[r] != '0) ? cnt[r] - TNEW_W'(1) : cnt[r];
  always_ff @(posedge clk or posedge reset)
    if (reset) md <= 5'd0;
    else md <= (accept && bus.issue_md) ? 5'(MD_CYCLES) : (md != 5'd0) ? md - 5'd1 : md;
endmodule

// File: tb/tb_tnew_scoreboard.sv
// tb_tnew_scoreboard: directed scenarios checked against a ready-time model of the scoreboard
module tb_tnew_scoreboard;
  localparam int MDC = 5;
  logic clk = 0;
  logic reset;
  int cmp = 0, bad = 0;
  int now_c = 0;
  int rdy [32];
  int md_until = 0;
  tnew_scoreboard_if #(.NREG(32), .TNEW_W(2)) bus ();
  tnew_scoreboard #(.NREG(32), .TNEW_W(2), .MD_CYCLES(MDC)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  function automatic int m_pend(input int r);
    return (r != 0 && rdy[r] > now_c) ? rdy[r] - now_c : 0;
  endfunction
  function automatic int m_busy();
    return md_until > now_c ? 1 : 0;
  endfunction
  function automatic int m_stall();
    if (reset || !bus.issue_valid) return 0;
    return (m_pend(int'(bus.rs)) > int'(bus.tuse_rs) || m_pend(int'(bus.rt)) > int'(bus.tuse_rt) ||
            (m_busy() == 1 && (bus.use_md || bus.issue_md))) ? 1 : 0;
  endfunction
  task automatic m_clear();
    for (int r = 0; r < 32; r++) rdy[r] = 0;
    md_until = 0;
  endtask
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    cmp++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", n, got, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    if (reset) begin
      m_clear();
      now_c++;
    end else begin
      automatic int acc = (bus.issue_valid && m_stall() == 0) ? 1 : 0;
      now_c++;
      if (acc == 1 && bus.issue_rd != 0) rdy[bus.issue_rd] = now_c + int'(bus.issue_tnew);
      if (acc == 1 && bus.issue_md) md_until = now_c + MDC;
    end
  end
  always @(negedge clk) begin
    chk("stall", 32'(bus.stall), 32'(m_stall()));
    chk("md_busy", 32'(bus.md_busy), 32'(m_busy()));
    chk("pend_rs", 32'(bus.pend_rs), 32'(m_pend(int'(bus.rs))));
    chk("pend_rt", 32'(bus.pend_rt), 32'(m_pend(int'(bus.rt))));
  end
  task automatic drv(input logic v, input int rd, input int tn, input logic md,
                     input int s, input int t, input int ts, input int tt, input logic um);
    @(posedge clk);
    #1;
    bus.issue_valid = v;
    bus.issue_rd = 5'(rd);
    bus.issue_tnew = 2'(tn);
    bus.issue_md = md;
    bus.rs = 5'(s);
    bus.rt = 5'(t);
    bus.tuse_rs = 2'(ts);
    bus.tuse_rt = 2'(tt);
    bus.use_md = um;
    @(negedge clk);
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    m_clear();
    reset = 1;
    bus.issue_valid = 1;
    bus.issue_rd = 5'd4;
    bus.issue_tnew = 2'd3;
    bus.issue_md = 1;
    bus.rs = 5'd4;
    bus.rt = 5'd4;
    bus.tuse_rs = 2'd0;
    bus.tuse_rt = 2'd0;
    bus.use_md = 1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", 32'(bus.stall), 0);
    chk("rst_pend", 32'(bus.pend_rs), 0);
    chk("rst_md", 32'(bus.md_busy), 0);
    @(posedge clk);
    #1;
    reset = 0;
    drv(1, 5, 2, 0, 0, 0, 0, 0, 0);
    chk("lw_issue", 32'(bus.stall), 0);
    drv(0, 0, 0, 0, 5, 0, 0, 0, 0);
    chk("lw_pend2", 32'(bus.pend_rs), 2);
    drv(1, 1, 1, 0, 5, 0, 0, 0, 0);
    chk("lw_stall", 32'(bus.stall), 1);
    chk("lw_pend1", 32'(bus.pend_rs), 1);
    drv(1, 1, 1, 0, 5, 1, 0, 0, 0);
    chk("lw_release", 32'(bus.stall), 0);
    chk("lw_pend0", 32'(bus.pend_rs), 0);
    chk("stalled_noload", 32'(bus.pend_rt), 0);
    drv(1, 8, 1, 0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 8, 0, 1, 0);
    chk("fwd_stall", 32'(bus.stall), 0);
    chk("fwd_pend", 32'(bus.pend_rt), 1);
    drv(1, 0, 2, 0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("zero_stall", 32'(bus.stall), 0);
    chk("zero_pend", 32'(bus.pend_rs), 0);
    drv(1, 7, 3, 0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 7, 7, 3, 1, 0);
    chk("same_stall", 32'(bus.stall), 1);
    chk("same_pend", 32'(bus.pend_rt), 3);
    drv(1, 0, 0, 0, 7, 7, 2, 2, 0);
    chk("same_equal", 32'(bus.stall), 0);
    drv(1, 0, 0, 1, 0, 0, 0, 0, 0);
    chk("md_start", 32'(bus.stall), 0);
    for (int i = 0; i < MDC; i++) begin
      drv(1, 0, 0, 0, 0, 0, 0, 0, 1);
      chk("md_win_stall", 32'(bus.stall), 1);
      chk("md_win_busy", 32'(bus.md_busy), 1);
    end
    drv(1, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("md_done_stall", 32'(bus.stall), 0);
    chk("md_done_busy", 32'(bus.md_busy), 0);
    drv(1, 3, 2, 0, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 3, 0, 0, 0, 0);
    chk("rl_pend2", 32'(bus.pend_rs), 2);
    drv(1, 3, 2, 0, 3, 3, 3, 3, 0);
    chk("rl_pend1", 32'(bus.pend_rs), 1);
    chk("rl_accept", 32'(bus.stall), 0);
    drv(0, 0, 0, 0, 3, 0, 0, 0, 0);
    chk("rl_reload", 32'(bus.pend_rs), 2);
    drv(1, 9, 2, 1, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 9, 0, 0, 0, 0);
    chk("mr_pend", 32'(bus.pend_rs), 2);
    chk("mr_busy", 32'(bus.md_busy), 1);
    bus.issue_valid = 1;
    bus.use_md = 1;
    #1;
    chk("mr_pre_stall", 32'(bus.stall), 1);
    reset = 1;
    m_clear();
    #1;
    chk("mr_rst_pend", 32'(bus.pend_rs), 0);
    chk("mr_rst_busy", 32'(bus.md_busy), 0);
    chk("mr_rst_stall", 32'(bus.stall), 0);
    reset = 0;
    #1;
    chk("mr_after_stall", 32'(bus.stall), 0);
    drv(1, 0, 0, 0, 9, 0, 0, 0, 1);
    chk("mr_dep_stall", 32'(bus.stall), 0);
    chk("mr_dep_pend", 32'(bus.pend_rs), 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
